// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and sequencer that is the only writer of one shared WIDTH-bit register.
// Latency: request sampled at E0, one-hot gnt during E0..E1, q/owner/valid updated at E1.
// Backpressure: a requester holds req and wdata until it sees gnt; clear takes priority over new grants.
module shared_reg_arbiter #(
    parameter int  WIDTH = 8,
    parameter int  NREQ  = 4,
    localparam int OW    = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    input  logic                  clr,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      q,
    output logic [OW-1:0]         owner,
    output logic                  valid,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, GRANT, CLEAR} state_t;

    state_t          state;
    logic [OW-1:0]   ptr;
    logic [OW-1:0]   win_idx;
    logic [OW-1:0]   win_nxt;
    logic [OW-1:0]   sel_start;
    logic [OW-1:0]   sel_idx;
    logic [OW-1:0]   cand;
    logic [NREQ-1:0] sel_mask;
    logic            sel_found;

    assign win_nxt = (win_idx == OW'(NREQ-1)) ? '0 : win_idx + 1'b1;

    // During GRANT the scan starts at the pointer being written this edge and skips the current winner.
    always_comb begin
        sel_mask  = (state == GRANT) ? (req & ~gnt) : req;
        sel_start = (state == GRANT) ? win_nxt : ptr;
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = OW'((int'(sel_start) + k) % NREQ);
            if (!sel_found && sel_mask[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            gnt     <= '0;
            q       <= '0;
            owner   <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            ptr     <= '0;
            win_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr) begin
                        state <= CLEAR;
                        busy  <= 1'b1;
                    end else if (sel_found) begin
                        state   <= GRANT;
                        gnt     <= NREQ'(1) << sel_idx;
                        win_idx <= sel_idx;
                        busy    <= 1'b1;
                    end
                end
                GRANT: begin
                    q     <= wdata[win_idx*WIDTH +: WIDTH];
                    owner <= win_idx;
                    valid <= 1'b1;
                    ptr   <= win_nxt;
                    if (clr) begin
                        state <= CLEAR;
                        gnt   <= '0;
                    end else if (sel_found) begin
                        state   <= GRANT;
                        gnt     <= NREQ'(1) << sel_idx;
                        win_idx <= sel_idx;
                    end else begin
                        state <= IDLE;
                        gnt   <= '0;
                        busy  <= 1'b0;
                    end
                end
                CLEAR: begin
                    q     <= '0;
                    valid <= 1'b0;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed test-plan steps followed by randomized requester traffic, all checked every cycle
// against a transaction-level model of the shared register.
module tb_shared_reg_arbiter;

    localparam int W = 8;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
    logic           clr;
    logic [N-1:0]   gnt;
    logic [W-1:0]   q;
    logic [1:0]     owner;
    logic           valid;
    logic           busy;

    int n_cmp = 0;
    int n_err = 0;

    // Model: the write in flight (-1 if none), a pending clear, and the architectural register.
    int         m_win   = -1;
    bit         m_clr   = 1'b0;
    logic [7:0] m_q     = '0;
    int         m_owner = 0;
    bit         m_valid = 1'b0;
    int         m_ptr   = 0;

    shared_reg_arbiter #(.WIDTH(W), .NREQ(N)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .wdata (wdata),
        .clr   (clr),
        .gnt   (gnt),
        .q     (q),
        .owner (owner),
        .valid (valid),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int excl;
        if (reset) begin
            m_win = -1; m_clr = 1'b0; m_q = '0; m_owner = 0; m_valid = 1'b0; m_ptr = 0;
        end else if (m_clr) begin
            m_q = '0; m_valid = 1'b0; m_clr = 1'b0;
        end else begin
            excl = -1;
            if (m_win >= 0) begin
                m_q     = wdata[m_win*W +: W];
                m_owner = m_win;
                m_valid = 1'b1;
                m_ptr   = (m_win + 1) % N;
                excl    = m_win;
            end
            m_win = -1;
            if (clr) begin
                m_clr = 1'b1;
            end else begin
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (m_ptr + k) % N;
                    if (m_win < 0 && req[i] && i != excl) m_win = i;
                end
            end
        end
    endtask

    task automatic tick();
        logic [3:0] exp_gnt;
        @(posedge clk);
        model_step();
        #1;
        exp_gnt = (m_win >= 0) ? (4'b0001 << m_win) : 4'b0000;
        chk("model_gnt",   32'(gnt),   32'(exp_gnt));
        chk("model_q",     32'(q),     32'(m_q));
        chk("model_owner", 32'(owner), 32'(m_owner));
        chk("model_valid", 32'(valid), 32'(m_valid));
        chk("model_busy",  32'(busy),  32'((m_win >= 0) || m_clr));
    endtask

    initial begin
        logic [3:0] gnt_prev;

        // Reset held with everything asserted.
        reset = 1'b1; req = 4'b1111; clr = 1'b1; wdata = '0;
        tick(); tick();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_owner", 32'(owner), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        // Full contention, each requester drops on its own grant.
        reset = 1'b0; clr = 1'b0; wdata = 32'h44332211;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("cont_gnt", 32'(gnt), 32'(4'b0001 << k));
            chk("cont_busy", 32'(busy), 32'h1);
            if (k > 0) chk("cont_q", 32'(q), 32'(wdata[(k-1)*W +: W]));
            req[k] = 1'b0;
        end
        tick();
        chk("cont_final_q", 32'(q), 32'h44);
        chk("cont_final_owner", 32'(owner), 32'h3);
        chk("cont_final_busy", 32'(busy), 32'h0);

        // Single writer.
        req = 4'b0001; wdata[7:0] = 8'hA5;
        tick(); chk("single_gnt", 32'(gnt), 32'h1);
        req = 4'b0000;
        tick();
        chk("single_gnt_off", 32'(gnt), 32'h0);
        chk("single_q", 32'(q), 32'hA5);
        chk("single_owner", 32'(owner), 32'h0);
        chk("single_valid", 32'(valid), 32'h1);
        chk("single_busy", 32'(busy), 32'h0);

        // Fairness and wrap: grant 2 moves the pointer to 3, so 0 wins before 2.
        req = 4'b0100; tick(); chk("fair_g2", 32'(gnt), 32'h4);
        req = 4'b0000; tick();
        req = 4'b0101; tick(); chk("fair_wrap", 32'(gnt), 32'h1);
        req = 4'b0100; tick(); chk("fair_next", 32'(gnt), 32'h4);
        req = 4'b0000; tick();
        req = 4'b0001;
        tick(); chk("hold_1", 32'(gnt), 32'h1);
        tick(); chk("hold_0", 32'(gnt), 32'h0);
        tick(); chk("hold_1b", 32'(gnt), 32'h1);
        tick(); chk("hold_0b", 32'(gnt), 32'h0);
        req = 4'b0000; tick();

        // Clear with a request pending.
        wdata[31:24] = 8'h44; req = 4'b1000; tick();
        req = 4'b0000; tick(); chk("pre_clr_q", 32'(q), 32'h44);
        clr = 1'b1; req = 4'b0010; wdata[15:8] = 8'h5A;
        tick(); chk("clr_busy", 32'(busy), 32'h1); chk("clr_gnt", 32'(gnt), 32'h0);
        clr = 1'b0;
        tick();
        chk("clr_q", 32'(q), 32'h0);
        chk("clr_valid", 32'(valid), 32'h0);
        chk("clr_gnt_idle", 32'(gnt), 32'h0);
        tick(); chk("post_clr_gnt", 32'(gnt), 32'h2);
        req = 4'b0000;
        tick(); chk("post_clr_q", 32'(q), 32'h5A);

        // Reset during the second grant of a 4-way contention.
        req = 4'b1111;
        tick(); tick();
        reset = 1'b1;
        tick();
        chk("midrst_gnt", 32'(gnt), 32'h0);
        chk("midrst_q", 32'(q), 32'h0);
        chk("midrst_valid", 32'(valid), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        tick(); chk("midrst_first_gnt", 32'(gnt), 32'h1);

        // Random traffic from handshaking requesters with occasional clear and reset.
        req = '0; clr = 1'b0; reset = 1'b0;
        gnt_prev = gnt;
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (gnt_prev[i] && req[i] && $urandom_range(0, 4) != 0) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    wdata[i*W +: W] = 8'($urandom);
                end
            end
            clr   = ($urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 99) == 0);
            gnt_prev = gnt;
        end
        reset = 1'b0; clr = 1'b0; req = '0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
